// File: rtl/rr_mux_reg_pkg.sv
// Shared definitions for the rr_mux_reg block.
//   MODE_FIXED / MODE_RR : values of the 'mode' input
//   clog2()              : ceiling log2 for index widths; usable in parameter defaults
package rr_mux_reg_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_reg_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
//   clk, rst_n : clock, async active-low reset
//   req        : per-channel request
//   advance    : move the pointer to the current grant (an accepted transfer)
//   gnt_oh     : one-hot grant
//   gnt_idx    : binary grant index
//   any_gnt    : at least one request is granted
// The search starts one past the last grant, so after reset (pointer =
// NUM_IN-1) channel 0 has first priority.
module rr_arbiter
  import rr_mux_reg_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [NUM_IN-1:0] gnt_oh,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  logic [SEL_W-1:0] last_grant;

  always_comb begin
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    j       = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!any_gnt && req[j]) begin
        any_gnt    = 1'b1;
        gnt_idx    = SEL_W'(j);
        gnt_oh[j]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  last_grant <= SEL_W'(NUM_IN - 1);
    else if (advance && any_gnt) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-input, n-bit multiplexer with registered output and valid/ready on
// every input and on the output. Selection is either the external binary
// select (mode=0) or an internal round-robin arbiter (mode=1).
//   clk, rst_n   : clock, async active-low reset
//   in_data      : packed channels, channel i at [i*n +: n]
//   in_valid     : per-channel valid
//   in_ready     : per-channel ready (combinational, never depends on in_data)
//   mode         : 0 = fixed select via bs, 1 = round-robin
//   bs           : binary select for fixed mode
//   out_data     : registered selected word
//   out_sel      : index of the channel that produced out_data
//   out_valid    : out_data holds a valid word
//   out_ready    : consumer ready
module rr_mux_reg
  import rr_mux_reg_pkg::*;
#(
  parameter int n      = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN*n-1:0] in_data,
  input  logic [NUM_IN-1:0]   in_valid,
  output logic [NUM_IN-1:0]   in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    bs,
  output logic [n-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [NUM_IN-1:0] rr_oh;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;

  logic [NUM_IN-1:0] gnt_oh;
  logic [SEL_W-1:0]  gidx;
  logic [n-1:0]      sel_data;
  logic              load;
  logic              take;
  logic              advance;

  // Register can accept a new word when empty or when its word leaves now.
  assign load = !out_valid || out_ready;

  rr_arbiter #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (advance),
    .gnt_oh  (rr_oh),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  // Grant: in fixed mode an out-of-range bs matches no channel, so no grant.
  always_comb begin
    gnt_oh = '0;
    gidx   = '0;
    if (mode == MODE_RR) begin
      if (rr_any) begin
        gnt_oh = rr_oh;
        gidx   = rr_idx;
      end
    end else begin
      gidx = bs;
      for (int i = 0; i < NUM_IN; i++) gnt_oh[i] = (int'(bs) == i);
    end
  end

  // Ready is held low during reset so producers never see a phantom accept.
  assign in_ready = (rst_n && load) ? gnt_oh : '0;

  // A word is captured only when the granted channel actually has data;
  // in fixed mode the selected channel may be idle.
  assign take    = |(gnt_oh & in_valid);
  assign advance = (mode == MODE_RR) && take && load;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (gnt_oh[i]) sel_data = in_data[i*n +: n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= take;
      if (take) begin
        out_data <= sel_data;
        out_sel  <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
module tb_rr_mux_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  bs;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  rr_mux_reg #(.n(8), .NUM_IN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .bs        (bs),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] bs;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_d;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic m, input logic [1:0] b, input logic [3:0] v,
                     input logic r, input logic [3:0] er, input logic eov,
                     input logic [7:0] ed, input logic [1:0] es);
    vec_t x;
    x.mode = m; x.bs = b; x.vld = v; x.ordy = r;
    x.exp_rdy = er; x.exp_ov = eov; x.exp_d = ed; x.exp_sel = es;
    vt.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // ch0=10 ch1=21 ch2=A5 ch3=43
    in_data   = 32'h43A5_2110;
    rst_n     = 1'b0;
    mode      = 1'b0;
    bs        = 2'd2;
    in_valid  = 4'b0100;
    out_ready = 1'b1;

    //      mode bs  valid   ordy  in_ready ov  data   sel
    add(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2); // fixed, ch2
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0); // RR from reset pointer
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3); // sparse: 3,1,3,1
    add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3);
    add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    for (int i = 0; i < 5; i++)                                  // stall holds word
      add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h21, 2'd1);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2); // release: drain+load
    // fixed bs=1 with ch1 idle: ch1 stays ready (fixed-mode ready ignores
    // valid) but nothing transfers, so the output empties and holds data/sel
    add(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0010, 1'b0, 8'hA5, 2'd2);
    add(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0010, 1'b0, 8'hA5, 2'd2);
    // back to RR: pointer still at 2 from the last RR transfer
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3);

    // reset state, with a would-be grant present on the inputs
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vt[i]) begin
      mode      = vt[i].mode;
      bs        = vt[i].bs;
      in_valid  = vt[i].vld;
      out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].exp_ov));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vt[i].exp_d));
      chk($sformatf("v%0d_out_sel", i),   32'(out_sel),   32'(vt[i].exp_sel));
    end

    // mid-burst reset between edges: output clears at once, ready drops
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    #2;
    rst_n    = 1'b1;
    in_valid = 4'b0110;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_out_data",  32'(out_data),  32'h21);
    chk("post_rst_out_sel",   32'(out_sel),   32'd1);
    chk("post_rst_in_ready2", 32'(in_ready),  32'b0100);
    @(posedge clk); #1;
    chk("post_rst_out_data2", 32'(out_data),  32'hA5);
    chk("post_rst_out_sel2",  32'(out_sel),   32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
